// File: rtl/cdc_rd_pack.sv
// cdc_rd_pack: read-side packer for the 2-entry CDC data FIFO.
// Pops narrow FIFO words, packs N_WORDS of them (first popped word in the
// least significant slot) and offers the packed word on a valid/ready
// handshake. A partial word can be emitted early through i_flush.
// Optional build macro CDC_RD_PACK_TIMEOUT_EN adds an idle counter that
// auto-flushes a partial word after TIMEOUT enabled cycles without a pop.

module cdc_rd_pack #(
    parameter int WIDTH   = 8,
    parameter int N_WORDS = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_cg,
    input  logic                         i_empty,
    input  logic [WIDTH-1:0]             i_data,
    output logic                         o_pop,
    input  logic                         i_flush,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [WIDTH*N_WORDS-1:0]     o_data,
    output logic [$clog2(N_WORDS):0]     o_count,
    output logic                         o_busy
);

    localparam int IDX_W = $clog2(N_WORDS);
    localparam int CNT_W = $clog2(N_WORDS) + 1;

    // Reject parameter values the packing logic cannot represent.
    if (WIDTH < 1 || N_WORDS < 2 || TIMEOUT < 1) begin : g_bad_params
        $error("cdc_rd_pack: needs WIDTH>=1, N_WORDS>=2, TIMEOUT>=1");
    end

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t                     state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [WIDTH*N_WORDS-1:0]   data_q, data_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic                       pop;
    logic                       last_slot;
    logic                       flush_req;

    // Pops only while filling; reset overrides everything so the FIFO is
    // never drained while the packer is being cleared.
    assign pop       = (state_q == ST_FILL) && !i_empty && i_cg && !i_rst;
    assign last_slot = (idx_q == IDX_W'(N_WORDS - 1));

`ifdef CDC_RD_PACK_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    logic [TMR_W-1:0] idle_q, idle_d;
    logic             timed_out;

    assign timed_out = (idle_q == TMR_W'(TIMEOUT));
    assign flush_req = i_flush || timed_out;

    // Idle counter: counts enabled pop-less cycles while a partial word is
    // held, saturates at TIMEOUT, and clears on a pop or on entering HOLD.
    always_comb begin
        idle_d = idle_q;
        if (i_cg) begin
            if (state_d == ST_HOLD) begin
                idle_d = '0;
            end else if (pop) begin
                idle_d = '0;
            end else if (state_q == ST_FILL && idx_q != '0 && !timed_out) begin
                idle_d = idle_q + TMR_W'(1);
            end
        end
    end

    // Idle counter register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    assign flush_req = i_flush;
`endif

    // Next-state logic: slot capture, completion on the last slot or on a
    // flush, and release of the packed word once the consumer takes it.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        count_d = count_q;
        if (i_cg) begin
            case (state_q)
                ST_FILL: begin
                    if (pop) begin
                        for (int s = 0; s < N_WORDS; s++) begin
                            if (idx_q == IDX_W'(s)) begin
                                data_d[s*WIDTH +: WIDTH] = i_data;
                            end
                        end
                        if (last_slot) begin
                            state_d = ST_HOLD;
                            count_d = CNT_W'(N_WORDS);
                            idx_d   = '0;
                        end else if (flush_req) begin
                            state_d = ST_HOLD;
                            count_d = CNT_W'(idx_q) + CNT_W'(1);
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else if (flush_req && idx_q != '0) begin
                        state_d = ST_HOLD;
                        count_d = CNT_W'(idx_q);
                        idx_d   = '0;
                    end
                end
                ST_HOLD: begin
                    if (i_ready) begin
                        state_d = ST_FILL;
                        data_d  = '0;
                        count_d = '0;
                        idx_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_FILL;
                end
            endcase
        end
    end

    // State, slot index, packed data and word count registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_FILL;
            idx_q   <= '0;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    assign o_pop   = pop;
    assign o_valid = (state_q == ST_HOLD);
    assign o_data  = data_q;
    assign o_count = count_q;
    assign o_busy  = (state_q == ST_HOLD) || (idx_q != '0);

endmodule

// File: tb/tb_cdc_rd_pack.sv
// tb_cdc_rd_pack: directed self-checking bench for cdc_rd_pack with
// WIDTH=8, N_WORDS=4, TIMEOUT=5. A queue stands in for the CDC FIFO read
// port. Build with CDC_RD_PACK_TIMEOUT_EN to exercise the auto-flush path.

module tb_cdc_rd_pack;

    localparam int WIDTH   = 8;
    localparam int N_WORDS = 4;
    localparam int TIMEOUT = 5;

    logic                     i_clk = 1'b0;
    logic                     i_rst;
    logic                     i_cg;
    logic                     i_empty;
    logic [WIDTH-1:0]         i_data;
    logic                     o_pop;
    logic                     i_flush;
    logic                     o_valid;
    logic                     i_ready;
    logic [WIDTH*N_WORDS-1:0] o_data;
    logic [2:0]               o_count;
    logic                     o_busy;

    int checks = 0;
    int passes = 0;

    logic [WIDTH-1:0] fifo_q[$];

    cdc_rd_pack #(
        .WIDTH  (WIDTH),
        .N_WORDS(N_WORDS),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_cg   (i_cg),
        .i_empty(i_empty),
        .i_data (i_data),
        .o_pop  (o_pop),
        .i_flush(i_flush),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_data (o_data),
        .o_count(o_count),
        .o_busy (o_busy)
    );

    // Free-running read clock.
    always #5 i_clk = ~i_clk;

    // FIFO model: a pop seen at the clock edge removes the head entry.
    always @(posedge i_clk) begin
        if (o_pop === 1'b1 && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
        end
    end

    task automatic refresh();
        i_empty = (fifo_q.size() == 0);
        i_data  = (fifo_q.size() == 0) ? '0 : fifo_q[0];
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
        refresh();
        #1;
    endtask

    task automatic reset_dut();
        i_rst   = 1'b1;
        i_cg    = 1'b1;
        i_flush = 1'b0;
        i_ready = 1'b0;
        fifo_q.delete();
        refresh();
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        i_rst   = 1'b1;
        i_cg    = 1'b1;
        i_flush = 1'b0;
        i_ready = 1'b0;
        fifo_q.delete();
        fifo_q.push_back(8'h11);
        refresh();
        #2;
        checks++;
        if (o_pop !== 1'b0) $display("[TB] FAIL reset_pop: got %b want 0", o_pop);
        else passes++;
        tick();
        tick();
        checks++;
        if ({o_valid, o_busy, o_count, o_data} !== {1'b0, 1'b0, 3'd0, 32'h0})
            $display("[TB] FAIL reset_state: got valid=%b busy=%b count=%0d data=%h want 0/0/0/0",
                     o_valid, o_busy, o_count, o_data);
        else passes++;
        fifo_q.delete();
        refresh();
        i_rst = 1'b0;
        #1;
    endtask

    task automatic test_full_word();
        reset_dut();
        i_ready = 1'b1;
        fifo_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        refresh();
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (o_pop !== 1'b1) $display("[TB] FAIL full_pop%0d: got %b want 1", k, o_pop);
            else passes++;
            tick();
        end
        checks++;
        if ({o_valid, o_pop, o_count, o_data} !== {1'b1, 1'b0, 3'd4, 32'h44332211})
            $display("[TB] FAIL full_word: got valid=%b pop=%b count=%0d data=%h want 1/0/4/44332211",
                     o_valid, o_pop, o_count, o_data);
        else passes++;
        tick();
        checks++;
        if ({o_valid, o_count, o_data} !== {1'b0, 3'd0, 32'h0})
            $display("[TB] FAIL full_release: got valid=%b count=%0d data=%h want 0/0/0",
                     o_valid, o_count, o_data);
        else passes++;
    endtask

    task automatic test_backpressure();
        reset_dut();
        fifo_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        refresh();
        for (int k = 0; k < 4; k++) tick();
        for (int k = 0; k < 10; k++) begin
            checks++;
            if ({o_valid, o_pop, o_count, o_data} !== {1'b1, 1'b0, 3'd4, 32'h44332211})
                $display("[TB] FAIL bp_hold%0d: got valid=%b pop=%b count=%0d data=%h want 1/0/4/44332211",
                         k, o_valid, o_pop, o_count, o_data);
            else passes++;
            tick();
        end
        i_ready = 1'b1;
        #1;
        checks++;
        if (o_pop !== 1'b0) $display("[TB] FAIL bp_handshake_pop: got %b want 0", o_pop);
        else passes++;
        tick();
        i_ready = 1'b0;
        checks++;
        if ({o_valid, o_pop} !== 2'b01)
            $display("[TB] FAIL bp_resume: got valid=%b pop=%b want 0/1", o_valid, o_pop);
        else passes++;
        tick();
        checks++;
        if ({o_busy, o_data} !== {1'b1, 32'h00000055})
            $display("[TB] FAIL bp_next_fill: got busy=%b data=%h want 1/00000055", o_busy, o_data);
        else passes++;
    endtask

    task automatic test_flush();
        reset_dut();
        fifo_q = '{8'hAA, 8'hBB};
        refresh();
        tick();
        tick();
        checks++;
        if ({o_busy, o_valid, i_empty} !== 3'b101)
            $display("[TB] FAIL flush_pre: got busy=%b valid=%b empty=%b want 1/0/1", o_busy, o_valid, i_empty);
        else passes++;
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        checks++;
        if ({o_valid, o_count, o_data} !== {1'b1, 3'd2, 32'h0000BBAA})
            $display("[TB] FAIL flush_two: got valid=%b count=%0d data=%h want 1/2/0000BBAA",
                     o_valid, o_count, o_data);
        else passes++;
        i_flush = 1'b1;
        tick();
        tick();
        i_flush = 1'b0;
        checks++;
        if ({o_valid, o_count, o_data} !== {1'b1, 3'd2, 32'h0000BBAA})
            $display("[TB] FAIL flush_in_hold: got valid=%b count=%0d data=%h want 1/2/0000BBAA",
                     o_valid, o_count, o_data);
        else passes++;
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        fifo_q = '{8'hAA, 8'hBB, 8'hCC};
        refresh();
        tick();
        tick();
        i_flush = 1'b1;
        #1;
        checks++;
        if (o_pop !== 1'b1) $display("[TB] FAIL flush_pop_cc: got %b want 1", o_pop);
        else passes++;
        tick();
        i_flush = 1'b0;
        checks++;
        if ({o_valid, o_count, o_data} !== {1'b1, 3'd3, 32'h00CCBBAA})
            $display("[TB] FAIL flush_with_pop: got valid=%b count=%0d data=%h want 1/3/00CCBBAA",
                     o_valid, o_count, o_data);
        else passes++;
    endtask

    task automatic test_flush_ignored();
        reset_dut();
        i_flush = 1'b1;
        tick();
        tick();
        i_flush = 1'b0;
        checks++;
        if ({o_valid, o_busy, o_count} !== {1'b0, 1'b0, 3'd0})
            $display("[TB] FAIL flush_idle: got valid=%b busy=%b count=%0d want 0/0/0",
                     o_valid, o_busy, o_count);
        else passes++;
    endtask

    task automatic test_clock_gate();
        reset_dut();
        fifo_q = '{8'h11, 8'h22};
        refresh();
        i_cg = 1'b0;
        #1;
        checks++;
        if (o_pop !== 1'b0) $display("[TB] FAIL cg_pop: got %b want 0", o_pop);
        else passes++;
        tick();
        tick();
        checks++;
        if ({o_busy, o_data} !== {1'b0, 32'h0})
            $display("[TB] FAIL cg_hold: got busy=%b data=%h want 0/0", o_busy, o_data);
        else passes++;
        i_cg = 1'b1;
        tick();
        tick();
        checks++;
        if ({o_busy, o_data} !== {1'b1, 32'h00002211})
            $display("[TB] FAIL cg_resume: got busy=%b data=%h want 1/00002211", o_busy, o_data);
        else passes++;
    endtask

    task automatic test_async_reset();
        reset_dut();
        fifo_q = '{8'h01, 8'h02, 8'h03, 8'h10, 8'h20, 8'h30, 8'h40};
        refresh();
        tick();
        tick();
        tick();
        checks++;
        if ({o_busy, o_data} !== {1'b1, 32'h00030201})
            $display("[TB] FAIL arst_pre: got busy=%b data=%h want 1/00030201", o_busy, o_data);
        else passes++;
        #1;
        i_rst = 1'b1;
        #1;
        checks++;
        if ({o_busy, o_pop, o_count, o_data} !== {1'b0, 1'b0, 3'd0, 32'h0})
            $display("[TB] FAIL arst_now: got busy=%b pop=%b count=%0d data=%h want 0/0/0/0",
                     o_busy, o_pop, o_count, o_data);
        else passes++;
        i_rst = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) tick();
        checks++;
        if ({o_valid, o_count, o_data} !== {1'b1, 3'd4, 32'h40302010})
            $display("[TB] FAIL arst_refill: got valid=%b count=%0d data=%h want 1/4/40302010",
                     o_valid, o_count, o_data);
        else passes++;
    endtask

    task automatic test_timeout();
        reset_dut();
        fifo_q = '{8'h5A};
        refresh();
        tick();
`ifdef CDC_RD_PACK_TIMEOUT_EN
        for (int k = 1; k <= 5; k++) begin
            tick();
            checks++;
            if (o_valid !== 1'b0) $display("[TB] FAIL timeout_early%0d: got valid=%b want 0", k, o_valid);
            else passes++;
        end
        tick();
        checks++;
        if ({o_valid, o_count, o_data} !== {1'b1, 3'd1, 32'h0000005A})
            $display("[TB] FAIL timeout_flush: got valid=%b count=%0d data=%h want 1/1/0000005A",
                     o_valid, o_count, o_data);
        else passes++;
`else
        begin
            logic sawValid;
            sawValid = 1'b0;
            for (int k = 0; k < 100; k++) begin
                tick();
                if (o_valid === 1'b1) sawValid = 1'b1;
            end
            checks++;
            if ({sawValid, o_busy, o_data} !== {1'b0, 1'b1, 32'h0000005A})
                $display("[TB] FAIL no_timeout: got sawValid=%b busy=%b data=%h want 0/1/0000005A",
                         sawValid, o_busy, o_data);
            else passes++;
        end
`endif
    endtask

    // Scenario sequence.
    initial begin
        i_rst   = 1'b1;
        i_cg    = 1'b1;
        i_flush = 1'b0;
        i_ready = 1'b0;
        i_empty = 1'b1;
        i_data  = '0;
        test_reset();
        test_full_word();
        test_backpressure();
        test_flush();
        test_flush_ignored();
        test_clock_gate();
        test_async_reset();
        test_timeout();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
